// File: rtl/timer_counter.sv
// Up/down timer counter aligned to a divided-clock tick, with load,
// sticky overflow/underflow flags and an interrupt request.
//
// state | meaning
// IDLE  | counting disabled, ticks ignored
// ARM   | enabled, waiting for the first tick to align to the divided clock
// COUNT | counting one step per tick
module timer_counter #(
  parameter int CNT_W = 8
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             cnt_tick,
  input  logic             cnt_en,
  input  logic             up_dwn,
  input  logic             load,
  input  logic [CNT_W-1:0] tdr,
  input  logic             ovf_clr,
  input  logic             udf_clr,
  input  logic             ovf_ie,
  input  logic             udf_ie,
  output logic [CNT_W-1:0] tcnt,
  output logic             ovf,
  output logic             udf,
  output logic             irq,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ARM, COUNT} state_t;

  state_t state;
  logic   step;
  logic   ovf_set;
  logic   udf_set;

  // A tick in the cycle cnt_en drops is dropped too, so tcnt holds on disable.
  assign step    = (state == COUNT) && cnt_en && cnt_tick && !load;
  assign ovf_set = step && !up_dwn && (tcnt == {CNT_W{1'b1}});
  assign udf_set = step &&  up_dwn && (tcnt == {CNT_W{1'b0}});

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state <= IDLE;
      busy  <= 1'b0;
      tcnt  <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cnt_en) state <= ARM;
        end
        ARM: begin
          if (!cnt_en) begin
            state <= IDLE;
          end else if (cnt_tick) begin
            state <= COUNT;
            busy  <= 1'b1;
          end
        end
        COUNT: begin
          if (!cnt_en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (load)
        tcnt <= tdr;
      else if (step)
        tcnt <= up_dwn ? tcnt - CNT_W'(1) : tcnt + CNT_W'(1);

      // Set wins over a same-cycle clear.
      ovf <= ovf_set | (ovf & ~ovf_clr);
      udf <= udf_set | (udf & ~udf_clr);
    end
  end

  assign irq = (ovf & ovf_ie) | (udf & udf_ie);

endmodule

// File: tb/tb_timer_counter.sv
// Directed and randomized checks of timer_counter against a behavioural
// model of count value, flags and enable phase.
module tb_timer_counter;
  localparam int W   = 8;
  localparam int MAX = 255;
  localparam int P_IDLE  = 0;
  localparam int P_ARM   = 1;
  localparam int P_COUNT = 2;

  logic         pclk = 1'b0;
  logic         presetn, cnt_tick, cnt_en, up_dwn, load;
  logic [W-1:0] tdr;
  logic         ovf_clr, udf_clr, ovf_ie, udf_ie;
  logic [W-1:0] tcnt;
  logic         ovf, udf, irq, busy;

  int vectors     = 0;
  int miscompares = 0;

  int m_cnt;
  bit m_ovf, m_udf;
  int m_phase;

  always #5 pclk = ~pclk;

  timer_counter #(.CNT_W(W)) dut (
    .pclk(pclk), .presetn(presetn), .cnt_tick(cnt_tick), .cnt_en(cnt_en),
    .up_dwn(up_dwn), .load(load), .tdr(tdr), .ovf_clr(ovf_clr),
    .udf_clr(udf_clr), .ovf_ie(ovf_ie), .udf_ie(udf_ie), .tcnt(tcnt),
    .ovf(ovf), .udf(udf), .irq(irq), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour for one pclk edge, from the current inputs.
  task automatic model_step();
    bit counting;
    if (!presetn) begin
      m_cnt = 0; m_ovf = 0; m_udf = 0; m_phase = P_IDLE;
    end else begin
      counting = (m_phase == P_COUNT) && cnt_en && cnt_tick && !load;
      if (load) begin
        m_cnt = int'(tdr);
        m_ovf = m_ovf && !ovf_clr;
        m_udf = m_udf && !udf_clr;
      end else if (counting && !up_dwn) begin
        m_ovf = (m_cnt == MAX) || (m_ovf && !ovf_clr);
        m_udf = m_udf && !udf_clr;
        m_cnt = (m_cnt + 1) % (MAX + 1);
      end else if (counting && up_dwn) begin
        m_udf = (m_cnt == 0) || (m_udf && !udf_clr);
        m_ovf = m_ovf && !ovf_clr;
        m_cnt = (m_cnt + MAX) % (MAX + 1);
      end else begin
        m_ovf = m_ovf && !ovf_clr;
        m_udf = m_udf && !udf_clr;
      end
      if (!cnt_en)                              m_phase = P_IDLE;
      else if (m_phase == P_IDLE)               m_phase = P_ARM;
      else if (m_phase == P_ARM && cnt_tick)    m_phase = P_COUNT;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge pclk);
    #1;
    chk("tcnt", 32'(tcnt), 32'(m_cnt));
    chk("ovf",  32'(ovf),  32'(m_ovf));
    chk("udf",  32'(udf),  32'(m_udf));
    chk("busy", 32'(busy), 32'(m_phase == P_COUNT));
    chk("irq",  32'(irq),  32'((m_ovf & ovf_ie) | (m_udf & udf_ie)));
  endtask

  task automatic tick(input int gap);
    cnt_tick = 1'b1;
    cycle();
    cnt_tick = 1'b0;
    for (int i = 0; i < gap; i++) cycle();
  endtask

  initial begin
    presetn = 0; cnt_tick = 0; cnt_en = 0; up_dwn = 0; load = 0; tdr = '0;
    ovf_clr = 0; udf_clr = 0; ovf_ie = 0; udf_ie = 0;
    m_cnt = 0; m_ovf = 0; m_udf = 0; m_phase = P_IDLE;
    @(negedge pclk);
    cycle(); cycle();
    chk("rst_tcnt", 32'(tcnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Enable, tick every 4 pclk: first tick only aligns.
    presetn = 1; cnt_en = 1;
    cycle(); cycle(); cycle();
    tick(3);
    chk("arm_busy", 32'(busy), 32'h1);
    chk("arm_tcnt", 32'(tcnt), 32'h0);
    for (int i = 0; i < 10; i++) tick(3);
    chk("ten_tcnt", 32'(tcnt), 32'd10);
    chk("ten_flags", 32'({ovf, udf}), 32'h0);

    // Up wrap through all-ones.
    load = 1; tdr = 8'hFE; cycle(); load = 0;
    tick(1); chk("wrap_ff", 32'(tcnt), 32'hFF);
    tick(1); chk("wrap_00", 32'(tcnt), 32'h00);
    chk("wrap_ovf", 32'(ovf), 32'h1);
    ovf_ie = 1; cycle();
    chk("ovf_irq", 32'(irq), 32'h1);
    tick(1); chk("wrap_01", 32'(tcnt), 32'h01);

    // Down wrap through zero.
    load = 1; tdr = 8'h01; cycle(); load = 0; up_dwn = 1;
    tick(1); chk("down_00", 32'(tcnt), 32'h00);
    tick(1); chk("down_ff", 32'(tcnt), 32'hFF);
    chk("down_udf", 32'(udf), 32'h1);
    chk("down_ovf", 32'(ovf), 32'h1);

    // Clear colliding with a set keeps the flag; clear alone drops it.
    up_dwn = 0; ovf_ie = 1; udf_ie = 0;
    load = 1; tdr = 8'hFF; cycle(); load = 0;
    ovf_clr = 1; tick(0); ovf_clr = 0;
    chk("clr_vs_set", 32'(ovf), 32'h1);
    ovf_clr = 1; cycle(); ovf_clr = 0;
    chk("clr_ovf", 32'(ovf), 32'h0);
    chk("clr_irq", 32'(irq), 32'h0);

    // Load beats a simultaneous wrapping tick and sets no flag.
    load = 1; tdr = 8'hFF; cycle();
    tdr = 8'h55; tick(0); load = 0;
    chk("load_pri", 32'(tcnt), 32'h55);
    chk("load_noflag", 32'(ovf), 32'h0);

    // Disable mid-count, ticks ignored, then reset.
    load = 1; tdr = 8'h20; cycle(); load = 0;
    cnt_en = 0;
    tick(1); tick(1); tick(1);
    chk("dis_tcnt", 32'(tcnt), 32'h20);
    chk("dis_busy", 32'(busy), 32'h0);
    presetn = 0; cycle();
    chk("rst_mid", 32'(tcnt), 32'h0);

    // Reset overrides a load and a wrapping tick in the same cycle.
    presetn = 1; cnt_en = 1; cycle(); tick(0);
    load = 1; tdr = 8'hFF; cycle(); load = 0;
    presetn = 0; load = 1; tdr = 8'h77; tick(0); load = 0;
    chk("rst_pri_tcnt", 32'(tcnt), 32'h0);
    chk("rst_pri_ovf", 32'(ovf), 32'h0);
    presetn = 1; cycle();
    tick(0); tick(0); tick(0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      presetn  = ($urandom_range(0, 99) != 0);
      cnt_en   = ($urandom_range(0, 19) != 0);
      cnt_tick = $urandom_range(0, 1);
      up_dwn   = ($urandom_range(0, 63) < 32) ? up_dwn : ~up_dwn;
      load     = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       tdr = 8'hFF;
        1:       tdr = 8'h00;
        default: tdr = W'($urandom);
      endcase
      ovf_clr  = ($urandom_range(0, 7) == 0);
      udf_clr  = ($urandom_range(0, 7) == 0);
      ovf_ie   = $urandom_range(0, 1);
      udf_ie   = $urandom_range(0, 1);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
